// File: rtl/ir_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and memory, the IR and the control unit.
// The slave modport is the sequencer's view. The master modport is the view of its environment.
interface ir_fetch_sequencer_if #(
  parameter int unsigned PC_WIDTH = 8
);
  logic                Start;
  logic                Halt;
  logic                MemReady;
  logic [7:0]          MemData;
  logic                ExecDone;
  logic                PCLoad;
  logic [PC_WIDTH-1:0] PCLoadValue;
  logic [PC_WIDTH-1:0] MemAddr;
  logic                MemRead;
  logic [7:0]          IRData;
  logic                IRWrite;
  logic                IRLH;
  logic                IRValid;
  logic [PC_WIDTH-1:0] PCOut;
  logic                Busy;
  logic [2:0]          State;

  modport slave (
    input  Start, Halt, MemReady, MemData, ExecDone, PCLoad, PCLoadValue,
    output MemAddr, MemRead, IRData, IRWrite, IRLH, IRValid, PCOut, Busy, State
  );

  modport master (
    output Start, Halt, MemReady, MemData, ExecDone, PCLoad, PCLoadValue,
    input  MemAddr, MemRead, IRData, IRWrite, IRLH, IRValid, PCOut, Busy, State
  );
endinterface

// File: rtl/ir_fetch_sequencer.sv
// Fetches a 16-bit instruction as two bytes at PC and PC+1 into the IR, then waits for execute.
// Define IR_FETCH_WAIT_STATE_EN to honour MemReady, with a stall counter that aborts after 255 stalls.
module ir_fetch_sequencer #(
  parameter int unsigned         PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic                 Clock,
  input logic                 Reset,
  ir_fetch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetchLo = 3'd1,
    StFetchHi = 3'd2,
    StExec    = 3'd3,
    StHalted  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                mem_ready;
  logic                stall_abort;
  logic                mem_read;
  logic                ir_write;
  logic                ir_lh;
  logic                ir_valid;

`ifdef IR_FETCH_WAIT_STATE_EN
  logic [7:0] stall_q, stall_d;

  assign mem_ready   = bus.MemReady;
  // A stall on this edge is the 255th in a row, so the fetch is abandoned.
  assign stall_abort = !mem_ready && (stall_q == 8'd254);

  always_comb begin
    stall_d = stall_q;
    if (state_d != state_q) begin
      stall_d = '0;
    end else if (mem_read && !mem_ready) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_mem_ready;

  assign unused_mem_ready = bus.MemReady;
  assign mem_ready        = 1'b1;
  assign stall_abort      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mem_read = 1'b0;
    ir_write = 1'b0;
    ir_lh    = 1'b0;
    ir_valid = 1'b0;
    unique case (state_q)
      StIdle, StHalted: begin
        if (bus.Start) begin
          state_d = StFetchLo;
        end
      end
      StFetchLo, StFetchHi: begin
        mem_read = 1'b1;
        ir_lh    = (state_q == StFetchHi);
        if (mem_ready) begin
          // IR captures the byte on the same edge that advances PC.
          ir_write = 1'b1;
          pc_d     = pc_q + PC_WIDTH'(1);
          state_d  = (state_q == StFetchHi) ? StExec : StFetchHi;
        end else if (stall_abort) begin
          state_d = StHalted;
        end
      end
      StExec: begin
        ir_valid = 1'b1;
        if (bus.ExecDone) begin
          if (bus.PCLoad) begin
            pc_d = bus.PCLoadValue;
          end
          state_d = bus.Halt ? StHalted : StFetchLo;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.MemAddr = pc_q;
  assign bus.PCOut   = pc_q;
  assign bus.MemRead = mem_read;
  assign bus.IRData  = bus.MemData;
  assign bus.IRWrite = ir_write;
  assign bus.IRLH    = ir_lh;
  assign bus.IRValid = ir_valid;
  assign bus.Busy    = (state_q == StFetchLo) || (state_q == StFetchHi) || (state_q == StExec);
  assign bus.State   = state_q;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Bench for ir_fetch_sequencer: random memory image and random control noise.
// It checks the DUT against a per-instruction model of PC, IR contents and state.
module tb_ir_fetch_sequencer;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  logic [7:0]  mem [256];
  logic [15:0] ir;
  logic [7:0]  exp_pc;

  ir_fetch_sequencer_if #(.PC_WIDTH(8)) bus ();

  ir_fetch_sequencer #(
    .PC_WIDTH(8),
    .RESET_PC(8'h10)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  assign bus.MemData = mem[bus.MemAddr];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // The instruction register that the sequencer loads.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ir <= '0;
    end else if (bus.IRWrite) begin
      if (bus.IRLH) ir[15:8] <= bus.IRData;
      else          ir[7:0]  <= bus.IRData;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Start       = 1'b0;
    bus.Halt        = 1'b0;
    bus.ExecDone    = 1'b0;
    bus.PCLoad      = 1'b0;
    bus.PCLoadValue = '0;
    bus.MemReady    = 1'b1;
  endtask

  task automatic fetch_noise();
    bus.Start       = 1'($urandom);
    bus.Halt        = 1'($urandom);
    bus.ExecDone    = 1'($urandom);
    bus.PCLoad      = 1'($urandom);
    bus.PCLoadValue = 8'($urandom);
`ifdef IR_FETCH_WAIT_STATE_EN
    bus.MemReady = 1'b1;
`else
    bus.MemReady = 1'($urandom);
`endif
  endtask

  // Runs one instruction. It is entered just after the edge that moved the DUT into FETCH_LO at exp_pc.
  task automatic do_instr(input logic load, input logic [7:0] target, input logic halt,
                          input int wait_cycles);
    logic [7:0] lo_addr;
    logic [7:0] hi_addr;
    lo_addr = exp_pc;
    hi_addr = exp_pc + 8'd1;
    for (int b = 0; b < 2; b++) begin
      fetch_noise();
      #1;
      checks++;
      if (bus.State !== 3'(b + 1)) begin
        errors++;
        $display("FAIL fetch_state: got %0d expected %0d", bus.State, b + 1);
      end
      checks++;
      if (bus.MemAddr !== (b == 0 ? lo_addr : hi_addr)) begin
        errors++;
        $display("FAIL fetch_addr: got %h expected %h", bus.MemAddr, (b == 0 ? lo_addr : hi_addr));
      end
      checks++;
      if ({bus.MemRead, bus.IRWrite, bus.IRLH, bus.IRValid, bus.Busy} !== {3'b110 | 3'(b), 2'b01}) begin
        errors++;
        $display("FAIL fetch_strobes: got %b expected %b",
                 {bus.MemRead, bus.IRWrite, bus.IRLH, bus.IRValid, bus.Busy}, {3'b110 | 3'(b), 2'b01});
      end
      checks++;
      if (bus.IRData !== mem[b == 0 ? lo_addr : hi_addr]) begin
        errors++;
        $display("FAIL fetch_irdata: got %h expected %h", bus.IRData, mem[b == 0 ? lo_addr : hi_addr]);
      end
      tick();
    end
    exp_pc = lo_addr + 8'd2;
    for (int i = 0; i <= wait_cycles; i++) begin
      bus.ExecDone    = (i == wait_cycles);
      bus.PCLoad      = (i == wait_cycles) ? load : 1'($urandom);
      bus.PCLoadValue = (i == wait_cycles) ? target : 8'($urandom);
      bus.Halt        = (i == wait_cycles) ? halt : 1'($urandom);
      bus.Start       = 1'($urandom);
      bus.MemReady    = 1'($urandom);
      #1;
      checks++;
      if ({bus.State, bus.IRValid, bus.MemRead, bus.IRWrite, bus.Busy} !== 7'b011_1001) begin
        errors++;
        $display("FAIL exec_outputs: got %b expected %b",
                 {bus.State, bus.IRValid, bus.MemRead, bus.IRWrite, bus.Busy}, 7'b011_1001);
      end
      checks++;
      if (bus.PCOut !== exp_pc) begin
        errors++;
        $display("FAIL exec_pc: got %h expected %h", bus.PCOut, exp_pc);
      end
      checks++;
      if (ir !== {mem[hi_addr], mem[lo_addr]}) begin
        errors++;
        $display("FAIL exec_ir: got %h expected %h", ir, {mem[hi_addr], mem[lo_addr]});
      end
      tick();
    end
    clear_inputs();
    if (load) exp_pc = target;
    checks++;
    if ({bus.State, bus.Busy} !== (halt ? 4'b100_0 : 4'b001_1)) begin
      errors++;
      $display("FAIL exec_next_state: got %b expected %b", {bus.State, bus.Busy},
               (halt ? 4'b100_0 : 4'b001_1));
    end
    checks++;
    if (bus.MemAddr !== exp_pc) begin
      errors++;
      $display("FAIL next_addr: got %h expected %h", bus.MemAddr, exp_pc);
    end
  endtask

  task automatic start_fetch();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.State, bus.IRWrite, bus.IRValid, bus.Busy, bus.MemRead} !== 7'b000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b",
               {bus.State, bus.IRWrite, bus.IRValid, bus.Busy, bus.MemRead}, 7'b0);
    end
    checks++;
    if (bus.PCOut !== 8'h10 || bus.MemAddr !== 8'h10) begin
      errors++;
      $display("FAIL reset_pc: got %h/%h expected 10", bus.PCOut, bus.MemAddr);
    end
    #2 Reset = 1'b1;
    tick();
    checks++;
    if (bus.State !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold: got %0d expected 0", bus.State);
    end
    exp_pc = 8'h10;
  endtask

  task automatic test_basic_fetch();
    mem[8'h10] = 8'hAB;
    mem[8'h11] = 8'hCD;
    start_fetch();
    do_instr(1'b0, 8'h00, 1'b0, 2);
    checks++;
    if (ir !== 16'hCDAB || exp_pc !== 8'h12) begin
      errors++;
      $display("FAIL basic_ir: got %h pc %h expected CDAB pc 12", ir, bus.PCOut);
    end
  endtask

  task automatic test_pc_load();
    do_instr(1'b1, 8'h40, 1'b0, 1);
    do_instr(1'b0, 8'h00, 1'b0, 0);
  endtask

  task automatic test_halt();
    logic [7:0] held;
    do_instr(1'b0, 8'h00, 1'b1, 1);
    held = exp_pc;
    for (int i = 0; i < 4; i++) begin
      bus.Halt     = 1'($urandom);
      bus.ExecDone = 1'($urandom);
      bus.PCLoad   = 1'($urandom);
      tick();
      checks++;
      if ({bus.State, bus.Busy, bus.MemRead} !== 5'b100_00 || bus.PCOut !== held) begin
        errors++;
        $display("FAIL halted_hold: got state %0d pc %h expected 4 pc %h", bus.State, bus.PCOut, held);
      end
    end
    clear_inputs();
    start_fetch();
    do_instr(1'b0, 8'h00, 1'b0, 0);
  endtask

  task automatic test_wrap();
    do_instr(1'b1, 8'hFF, 1'b0, 0);
    do_instr(1'b0, 8'h00, 1'b0, 1);
    checks++;
    if (exp_pc !== 8'h01 || ir !== {mem[8'h00], mem[8'hFF]}) begin
      errors++;
      $display("FAIL wrap: got pc %h ir %h expected pc 01", bus.PCOut, ir);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      do_instr(1'($urandom), 8'($urandom), 1'b0, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    checks++;
    if (bus.State !== 3'd2 || bus.IRWrite !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_fetch_hi: got state %0d irwrite %b expected 2/1", bus.State, bus.IRWrite);
    end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if ({bus.State, bus.IRWrite, bus.MemRead, bus.Busy} !== 6'b000_000 || bus.PCOut !== 8'h10) begin
      errors++;
      $display("FAIL async_reset: got state %0d irwrite %b pc %h expected 0/0/10",
               bus.State, bus.IRWrite, bus.PCOut);
    end
    #1 Reset = 1'b1;
    tick();
    checks++;
    if (bus.State !== 3'd0 || bus.PCOut !== 8'h10) begin
      errors++;
      $display("FAIL post_reset: got state %0d pc %h expected 0/10", bus.State, bus.PCOut);
    end
    exp_pc = 8'h10;
  endtask

`ifdef IR_FETCH_WAIT_STATE_EN
  task automatic test_wait_state();
    start_fetch();
    bus.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.State, bus.IRWrite, bus.MemRead} !== 5'b001_01 || bus.PCOut !== exp_pc) begin
        errors++;
        $display("FAIL short_stall: got state %0d irwrite %b pc %h expected 1/0/%h",
                 bus.State, bus.IRWrite, bus.PCOut, exp_pc);
      end
      tick();
    end
    do_instr(1'b0, 8'h00, 1'b0, 0);
    bus.MemReady = 1'b0;
    for (int i = 0; i < 255; i++) begin
      checks++;
      if (bus.State !== 3'd1) begin
        errors++;
        $display("FAIL long_stall_cycle%0d: got state %0d expected 1", i, bus.State);
      end
      tick();
    end
    checks++;
    if (bus.State !== 3'd4 || bus.PCOut !== exp_pc || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_abort: got state %0d pc %h expected 4 pc %h", bus.State, bus.PCOut, exp_pc);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    Reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic_fetch();
    test_pc_load();
    test_halt();
    test_wrap();
    test_random();
    test_reset_mid_fetch();
`ifdef IR_FETCH_WAIT_STATE_EN
    test_wait_state();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
